// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
//
// Execute-stage condition and flag unit. It sits directly after the ALU.
//
// What it does:
//   - Holds the architectural NZCV flag register.
//   - Evaluates each instruction's condition field against the registered
//     flags.
//   - Updates the flags from the ALU under per-group write enables.
//   - Gates the PC/register/memory write controls and registers them into
//     the Memory stage.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, clears all state
//   ALUFlags   in   [3:0] ALU flags {N,Z,C,V} of the Execute instruction
//   Cond       in   [3:0] instruction condition field
//   FlagW      in   [1:0] [1] writes N,Z ; [0] writes C,V
//   PCS        in   instruction writes PC
//   RegW       in   instruction writes register file
//   MemW       in   instruction writes memory
//   NoWrite    in   compare-type op, suppresses RegW
//   Stall      in   hold Execute instruction and all state
//   Flush      in   squash Execute instruction
//   Flags      out  [3:0] current flag register {N,Z,C,V}
//   CondEx     out  combinational condition result
//   PCSrcM     out  registered gated PCS
//   RegWriteM  out  registered gated RegW
//   MemWriteM  out  registered gated MemW
// ---------------------------------------------------------------------------
module cond_logic (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ALUFlags,
   input  logic [3:0] Cond,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   input  logic       Stall,
   input  logic       Flush,
   output logic [3:0] Flags,
   output logic       CondEx,
   output logic       PCSrcM,
   output logic       RegWriteM,
   output logic       MemWriteM
);

   logic [1:0] nz_reg;   // {N,Z}
   logic [1:0] cv_reg;   // {C,V}
   logic       pcs_m_reg;
   logic       regw_m_reg;
   logic       memw_m_reg;

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ex_next;
   logic wr_nz, wr_cv;
   logic pcs_gated, regw_gated, memw_gated;

   assign flag_n = nz_reg[1];
   assign flag_z = nz_reg[0];
   assign flag_c = cv_reg[1];
   assign flag_v = cv_reg[0];

   // The condition looks only at the registered flags. An instruction's own
   // ALUFlags therefore never influence its own condition.
   always_comb begin
      cond_ex_next = 1'b0;
      unique case (Cond)
         4'b0000: cond_ex_next = flag_z;
         4'b0001: cond_ex_next = ~flag_z;
         4'b0010: cond_ex_next = flag_c;
         4'b0011: cond_ex_next = ~flag_c;
         4'b0100: cond_ex_next = flag_n;
         4'b0101: cond_ex_next = ~flag_n;
         4'b0110: cond_ex_next = flag_v;
         4'b0111: cond_ex_next = ~flag_v;
         4'b1000: cond_ex_next = flag_c & ~flag_z;
         4'b1001: cond_ex_next = ~flag_c | flag_z;
         4'b1010: cond_ex_next = (flag_n == flag_v);
         4'b1011: cond_ex_next = (flag_n != flag_v);
         4'b1100: cond_ex_next = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex_next = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex_next = 1'b1;
         default: cond_ex_next = 1'b0;
      endcase
   end

   // A stalled or squashed instruction must not disturb the flags.
   assign wr_nz = FlagW[1] & cond_ex_next & ~Stall & ~Flush;
   assign wr_cv = FlagW[0] & cond_ex_next & ~Stall & ~Flush;

   assign pcs_gated  = PCS  & cond_ex_next;
   assign regw_gated = RegW & cond_ex_next & ~NoWrite;
   assign memw_gated = MemW & cond_ex_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         nz_reg <= 2'b00;
         cv_reg <= 2'b00;
      end else begin
         if (wr_nz) nz_reg <= ALUFlags[3:2];
         if (wr_cv) cv_reg <= ALUFlags[1:0];
      end
   end

   // Flush has priority over Stall, so a squashed slot becomes a bubble
   // even while the stage is held.
   always_ff @(posedge clk) begin
      if (reset || Flush) begin
         pcs_m_reg  <= 1'b0;
         regw_m_reg <= 1'b0;
         memw_m_reg <= 1'b0;
      end else if (!Stall) begin
         pcs_m_reg  <= pcs_gated;
         regw_m_reg <= regw_gated;
         memw_m_reg <= memw_gated;
      end
   end

   assign Flags     = {nz_reg, cv_reg};
   assign CondEx    = cond_ex_next;
   assign PCSrcM    = pcs_m_reg;
   assign RegWriteM = regw_m_reg;
   assign MemWriteM = memw_m_reg;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

   logic       clk;
   logic       reset;
   logic [3:0] ALUFlags;
   logic [3:0] Cond;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite, Stall, Flush;
   logic [3:0] Flags;
   logic       CondEx, PCSrcM, RegWriteM, MemWriteM;

   cond_logic dut (
      .clk       (clk),
      .reset     (reset),
      .ALUFlags  (ALUFlags),
      .Cond      (Cond),
      .FlagW     (FlagW),
      .PCS       (PCS),
      .RegW      (RegW),
      .MemW      (MemW),
      .NoWrite   (NoWrite),
      .Stall     (Stall),
      .Flush     (Flush),
      .Flags     (Flags),
      .CondEx    (CondEx),
      .PCSrcM    (PCSrcM),
      .RegWriteM (RegWriteM),
      .MemWriteM (MemWriteM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] flags;
      logic       pcs;
      logic       regw;
      logic       memw;
   } exp_t;

   exp_t exp_q[$];

   int check_count = 0;
   int error_count = 0;

   // model state
   logic [3:0] m_flags;
   logic       m_pcs, m_regw, m_memw;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic cond_fn(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !cf || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clocked transaction: drive, check CondEx, push expectation,
   // then compare registered state after the edge.
   task automatic cycle(input logic rst, input logic [3:0] alu, input logic [3:0] cnd,
                        input logic [1:0] fw, input logic pcs, input logic regw,
                        input logic memw, input logic nw, input logic st, input logic fl);
      logic ce;
      exp_t e;
      @(negedge clk);
      reset = rst; ALUFlags = alu; Cond = cnd; FlagW = fw;
      PCS = pcs; RegW = regw; MemW = memw; NoWrite = nw; Stall = st; Flush = fl;
      #1;
      ce = cond_fn(cnd, m_flags);
      check("condex", {7'b0, CondEx}, {7'b0, ce});
      if (rst) begin
         m_flags = 4'b0000;
         m_pcs = 1'b0; m_regw = 1'b0; m_memw = 1'b0;
      end else begin
         if (fw[1] && ce && !st && !fl) m_flags[3:2] = alu[3:2];
         if (fw[0] && ce && !st && !fl) m_flags[1:0] = alu[1:0];
         if (fl) begin
            m_pcs = 1'b0; m_regw = 1'b0; m_memw = 1'b0;
         end else if (!st) begin
            m_pcs  = pcs && ce;
            m_regw = regw && ce && !nw;
            m_memw = memw && ce;
         end
      end
      exp_q.push_back('{flags: m_flags, pcs: m_pcs, regw: m_regw, memw: m_memw});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("flags", {4'b0, Flags}, {4'b0, e.flags});
      check("pcsrcm", {7'b0, PCSrcM}, {7'b0, e.pcs});
      check("regwritem", {7'b0, RegWriteM}, {7'b0, e.regw});
      check("memwritem", {7'b0, MemWriteM}, {7'b0, e.memw});
      $display("txn rst=%0b alu=%b cond=%b fw=%b pcs=%0b rw=%0b mw=%0b nw=%0b st=%0b fl=%0b -> flags=%b m=%0b%0b%0b",
               rst, alu, cnd, fw, pcs, regw, memw, nw, st, fl, Flags, PCSrcM, RegWriteM, MemWriteM);
   endtask

   // Combinational probe of CondEx between edges, with flag writes disabled.
   task automatic peek(input string tag, input logic [3:0] cnd, input logic exp);
      Cond = cnd; FlagW = 2'b00;
      #1;
      check(tag, {7'b0, CondEx}, {7'b0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ALUFlags = 4'b0; Cond = 4'b0; FlagW = 2'b0;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0; Flush = 1'b0;
      m_flags = 4'b0; m_pcs = 1'b0; m_regw = 1'b0; m_memw = 1'b0;

      // reset state
      cycle(1, 4'hF, 4'hE, 2'b11, 1, 1, 1, 0, 0, 0);
      cycle(1, 4'hF, 4'hE, 2'b11, 1, 1, 1, 0, 0, 0);
      check("rst_flags", {4'b0, Flags}, 8'h00);
      check("rst_m", {5'b0, PCSrcM, RegWriteM, MemWriteM}, 8'h00);
      peek("rst_eq", 4'b0000, 1'b0);
      peek("rst_al", 4'b1110, 1'b1);

      // AL flag write and register write
      cycle(0, 4'b0100, 4'b1110, 2'b11, 0, 1, 0, 0, 0, 0);
      check("tp1_flags", {4'b0, Flags}, 8'h04);
      check("tp1_regw", {7'b0, RegWriteM}, 8'h01);
      peek("tp1_eq", 4'b0000, 1'b1);

      // failed NE condition
      cycle(0, 4'b1010, 4'b0001, 2'b11, 0, 1, 1, 0, 0, 0);
      check("tp2_flags", {4'b0, Flags}, 8'h04);
      check("tp2_m", {6'b0, RegWriteM, MemWriteM}, 8'h00);

      // partial writes
      cycle(0, 4'b0000, 4'b1110, 2'b11, 0, 0, 0, 0, 0, 0);
      cycle(0, 4'b1111, 4'b1110, 2'b01, 0, 0, 0, 0, 0, 0);
      check("tp3_cv", {4'b0, Flags}, 8'h03);
      cycle(0, 4'b1000, 4'b1110, 2'b10, 0, 0, 0, 0, 0, 0);
      check("tp3_nz", {4'b0, Flags}, 8'h0B);

      // full sweep of condition codes against every flag value
      for (int f = 0; f < 16; f++) begin
         cycle(0, 4'(f), 4'b1110, 2'b11, 0, 0, 0, 0, 0, 0);
         for (int c = 0; c < 16; c++) peek("sweep", 4'(c), cond_fn(4'(c), 4'(f)));
         if (f == 9) begin
            peek("ge_nv11", 4'b1010, 1'b1);
            peek("lt_nv11", 4'b1011, 1'b0);
            peek("nv_never", 4'b1111, 1'b0);
         end
      end

      // CMP: flags updated, register write suppressed
      cycle(0, 4'b0110, 4'b1110, 2'b11, 0, 1, 0, 1, 0, 0);
      check("cmp_regw", {7'b0, RegWriteM}, 8'h00);
      check("cmp_flags", {4'b0, Flags}, 8'h06);
      cycle(0, 4'b0110, 4'b1110, 2'b00, 1, 0, 0, 0, 0, 0);
      check("pcs_m", {7'b0, PCSrcM}, 8'h01);

      // stall holds flags and M stage
      for (int i = 0; i < 3; i++) begin
         cycle(0, 4'b1111, 4'b1110, 2'b11, 0, 0, 0, 0, 1, 0);
         check("stall_flags", {4'b0, Flags}, 8'h06);
         check("stall_pcs", {7'b0, PCSrcM}, 8'h01);
      end
      // flush during stall gives a bubble, no flag write
      cycle(0, 4'b1111, 4'b1110, 2'b11, 1, 1, 1, 0, 1, 1);
      check("flush_m", {5'b0, PCSrcM, RegWriteM, MemWriteM}, 8'h00);
      check("flush_flags", {4'b0, Flags}, 8'h06);
      // rebuild state, then reset while stalled
      cycle(0, 4'b1001, 4'b1110, 2'b11, 1, 1, 1, 0, 0, 0);
      cycle(1, 4'b1111, 4'b1110, 2'b11, 1, 1, 1, 0, 1, 0);
      check("rst_stall", {1'b0, Flags, PCSrcM, RegWriteM, MemWriteM}, 8'h00);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 40) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
